// File: rtl/fpmul_seq_arbiter_if.sv
// fpmul_seq_arbiter_if: requester, response and wrapper-bus signals of the shared FP multiply arbiter
//   req_valid/req_opa/req_opb/req_ready : per-requester job handshake (32-bit operand slices)
//   rsp_valid/rsp_id/rsp_p/rsp_flags/rsp_timeout : shared response strobe and payload
//   busy : arbiter not idle
//   fpw_a/fpw_we/fpw_wdata/fpw_rdata : memory-mapped bus to the FP multiply wrapper
interface fpmul_seq_arbiter_if #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
);
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_opa;
    logic [32*NREQ-1:0]   req_opb;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [31:0]          rsp_p;
    logic [5:0]           rsp_flags;
    logic                 rsp_timeout;
    logic                 busy;
    logic [1:0]           fpw_a;
    logic                 fpw_we;
    logic [31:0]          fpw_wdata;
    logic [31:0]          fpw_rdata;
    modport master (
        input  req_valid, req_opa, req_opb, fpw_rdata,
        output req_ready, rsp_valid, rsp_id, rsp_p, rsp_flags, rsp_timeout, busy, fpw_a, fpw_we, fpw_wdata
    );
    modport slave (
        output req_valid, req_opa, req_opb, fpw_rdata,
        input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_flags, rsp_timeout, busy, fpw_a, fpw_we, fpw_wdata
    );
endinterface

// File: rtl/fpmul_seq_arbiter.sv
// fpmul_seq_arbiter: round-robin sharing of one memory-mapped FP multiply wrapper among NREQ requesters
//   clk, rst : clock, synchronous active-high reset
//   bus      : fpmul_seq_arbiter_if.master (requests in, one-hot grant out, response out, wrapper bus out/rdata in)
module fpmul_seq_arbiter #(
    parameter int NREQ     = 2,
    parameter int ID_W     = 1,
    parameter int POLL_MAX = 64
) (
    input logic clk,
    input logic rst,
    fpmul_seq_arbiter_if.master bus
);
    localparam int CW = $clog2(POLL_MAX + 1);
    typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_GO, POLL, RD_RES, RESP} state_t;
    state_t          state_q, state_d;
    logic [31:0]     opa_q, opa_d, opb_q, opb_d, p_q, p_d;
    logic [ID_W-1:0] id_q, id_d, last_q, last_d, rid_q, rid_d, gid;
    logic [5:0]      flg_q, flg_d, rflg_q, rflg_d;
    logic            to_q, to_d, found;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt;
    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        gid   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && bus.req_valid[(int'(last_q) + k) % NREQ]) begin
                found = 1'b1;
                gid   = ID_W'((int'(last_q) + k) % NREQ);
            end
        end
    end
    assign gnt = (state_q == IDLE && found && !rst) ? NREQ'(1) << gid : '0;
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        id_d    = id_q;
        last_d  = last_q;
        flg_d   = flg_q;
        p_d     = p_q;
        rflg_d  = rflg_q;
        rid_d   = rid_q;
        to_d    = to_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: if (|gnt) begin
                opa_d   = bus.req_opa[32*int'(gid) +: 32];
                opb_d   = bus.req_opb[32*int'(gid) +: 32];
                id_d    = gid;
                last_d  = gid;
                state_d = WR_A;
            end
            WR_A:  state_d = WR_B;
            WR_B:  state_d = WR_GO;
            WR_GO: begin
                cnt_d   = CW'(1);
                state_d = POLL;
            end
            // The first poll may still show Done from the previous job, so it is skipped.
            POLL: if (cnt_q != CW'(1) && bus.fpw_rdata[0]) begin
                flg_d   = bus.fpw_rdata[13:8];
                state_d = RD_RES;
            end else if (cnt_q == CW'(POLL_MAX)) begin
                p_d     = '0;
                rflg_d  = '0;
                to_d    = 1'b1;
                rid_d   = id_q;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RD_RES: begin
                p_d     = bus.fpw_rdata;
                rflg_d  = flg_q;
                to_d    = 1'b0;
                rid_d   = id_q;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            id_q    <= '0;
            last_q  <= ID_W'(NREQ - 1);
            flg_q   <= '0;
            p_q     <= '0;
            rflg_q  <= '0;
            rid_q   <= '0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            id_q    <= id_d;
            last_q  <= last_d;
            flg_q   <= flg_d;
            p_q     <= p_d;
            rflg_q  <= rflg_d;
            rid_q   <= rid_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.req_ready   = gnt;
    assign bus.rsp_valid   = state_q == RESP;
    assign bus.rsp_id      = rid_q;
    assign bus.rsp_p       = p_q;
    assign bus.rsp_flags   = rflg_q;
    assign bus.rsp_timeout = to_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.fpw_a       = state_q == WR_A ? 2'd0 : state_q == WR_B ? 2'd1 :
                             (state_q == WR_GO || state_q == RD_RES) ? 2'd2 : 2'd3;
    assign bus.fpw_we      = state_q == WR_A || state_q == WR_B || state_q == WR_GO;
    assign bus.fpw_wdata   = state_q == WR_A ? opa_q : state_q == WR_B ? opb_q :
                             state_q == WR_GO ? 32'h0001_0000 : 32'h0;
endmodule

// File: tb/tb_fpmul_seq_arbiter.sv
// tb_fpmul_seq_arbiter: directed scoreboard bench for fpmul_seq_arbiter with a behavioural wrapper model
module tb_fpmul_seq_arbiter;
    localparam int NREQ = 2;
    localparam int ID_W = 1;
    localparam int PM   = 16;
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     p;
        logic [5:0]      f;
        logic            t;
    } rsp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fpmul_seq_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus();
    fpmul_seq_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .POLL_MAX(PM)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );
    rsp_t        sb[$];
    logic [33:0] wq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] opa_w = '0, opb_w = '0, fixed_res = '0;
    logic        fixed_en = 1'b0, start_w = 1'b0, done;
    logic [63:0] mask = '0;
    logic [5:0]  flg_cfg = '0;
    int          poll_n = 0;
    // Wrapper model: Done follows a per-job pattern indexed by poll number since Start.
    assign done = poll_n < 64 ? mask[poll_n] : 1'b0;
    assign bus.fpw_rdata = bus.fpw_a == 2'd2 ? (fixed_en ? fixed_res : opa_w ^ opb_w) :
                           bus.fpw_a == 2'd3 ? {15'b0, start_w, 2'b0, flg_cfg, 7'b0, done} : 32'h0;
    always @(posedge clk) begin
        if (bus.fpw_we) begin
            wq.push_back({bus.fpw_a, bus.fpw_wdata});
            if (bus.fpw_a == 2'd0) opa_w <= bus.fpw_wdata;
            if (bus.fpw_a == 2'd1) opb_w <= bus.fpw_wdata;
            if (bus.fpw_a == 2'd2) begin
                start_w <= bus.fpw_wdata[16];
                poll_n  <= 0;
            end
        end else if (bus.busy && bus.fpw_a == 2'd3) begin
            poll_n <= poll_n + 1;
        end
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic push_exp(input int g, input logic [31:0] p, input logic [5:0] f, input logic t);
        rsp_t e;
        e.id = ID_W'(g);
        e.p  = p;
        e.f  = f;
        e.t  = t;
        sb.push_back(e);
    endtask
    task automatic handshake(input string tag, output int gid);
        gid = -1;
        for (int n = 0; n < 40 && gid < 0; n++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++)
                if (bus.req_ready[i] && bus.req_valid[i]) gid = i;
        end
        chk({tag, "_grant_seen"}, 64'(gid >= 0), 1);
        if (gid >= 0) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic wait_rsp(input string tag, input int lat);
        rsp_t e;
        int   n;
        bit   seen = 1'b0;
        for (n = 1; n < 60; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
        end
        chk({tag, "_rsp_seen"}, 64'(seen), 1);
        chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_latency"}, 64'(n), 64'(lat));
            chk({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'(e.id));
            chk({tag, "_rsp_p"}, 64'(bus.rsp_p), 64'(e.p));
            chk({tag, "_rsp_flags"}, 64'(bus.rsp_flags), 64'(e.f));
            chk({tag, "_rsp_timeout"}, 64'(bus.rsp_timeout), 64'(e.t));
        end
    endtask
    initial begin
        int          g, cnt;
        logic [33:0] ew[3];
        bus.req_valid = '1;
        bus.req_opa   = '0;
        bus.req_opb   = '0;
        @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_fpw_we", 64'(bus.fpw_we), 0);
        chk("rst_fpw_a", 64'(bus.fpw_a), 3);
        chk("rst_fpw_wdata", 64'(bus.fpw_wdata), 0);
        chk("rst_rsp_payload", 64'({bus.rsp_id, bus.rsp_p, bus.rsp_flags, bus.rsp_timeout}), 0);
        bus.req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        // Basic job: Done on the 4th poll.
        bus.req_opa[31:0] = 32'h4000_0000;
        bus.req_opb[31:0] = 32'h4040_0000;
        fixed_en  = 1'b1;
        fixed_res = 32'h40C0_0000;
        mask      = 64'h8;
        flg_cfg   = 6'b0;
        wq.delete();
        bus.req_valid = 2'b01;
        handshake("t1", g);
        chk("t1_gid", 64'(g), 0);
        push_exp(0, 32'h40C0_0000, 6'b0, 1'b0);
        bus.req_valid = 2'b00;
        wait_rsp("t1", 9);
        ew[0] = {2'd0, 32'h4000_0000};
        ew[1] = {2'd1, 32'h4040_0000};
        ew[2] = {2'd2, 32'h0001_0000};
        chk("t1_nwrites", 64'(wq.size()), 3);
        for (int i = 0; i < 3 && i < wq.size(); i++) chk("t1_write", 64'(wq[i]), 64'(ew[i]));
        @(negedge clk);
        chk("t1_rsp_valid_pulse", 64'(bus.rsp_valid), 0);
        chk("t1_rsp_p_hold", 64'(bus.rsp_p), 64'h40C0_0000);
        chk("t1_busy_idle", 64'(bus.busy), 0);
        // Both requesters held for four jobs after reset: alternate grants.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.req_opa = {32'h3333_3333, 32'h1111_1111};
        bus.req_opb = {32'h0F0F_0F0F, 32'h2222_2222};
        fixed_en = 1'b0;
        mask     = 64'h2;
        bus.req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            handshake("t2", g);
            chk("t2_grant_order", 64'(g), 64'(j % 2));
            push_exp(g, g == 0 ? 32'h1111_1111 ^ 32'h2222_2222 : 32'h3333_3333 ^ 32'h0F0F_0F0F, 6'b0, 1'b0);
            wait_rsp("t2", 7);
        end
        bus.req_valid = 2'b00;
        // Timeout: Done never rises; flags must still read as 0.
        mask    = 64'h0;
        flg_cfg = 6'h3F;
        bus.req_valid = 2'b01;
        handshake("t3", g);
        chk("t3_gid", 64'(g), 0);
        push_exp(0, 32'h0, 6'b0, 1'b1);
        bus.req_valid = 2'b00;
        wait_rsp("t3", 4 + PM);
        @(negedge clk);
        chk("t3_busy_after", 64'(bus.busy), 0);
        // Flag extraction from the status word.
        fixed_en  = 1'b1;
        fixed_res = 32'h3F80_0000;
        mask      = 64'h2;
        flg_cfg   = 6'b100000;
        bus.req_valid = 2'b10;
        handshake("t4a", g);
        chk("t4a_gid", 64'(g), 1);
        push_exp(1, 32'h3F80_0000, 6'b100000, 1'b0);
        bus.req_valid = 2'b00;
        wait_rsp("t4a", 7);
        flg_cfg = 6'b000001;
        bus.req_valid = 2'b01;
        handshake("t4b", g);
        chk("t4b_gid", 64'(g), 0);
        push_exp(0, 32'h3F80_0000, 6'b000001, 1'b0);
        bus.req_valid = 2'b00;
        wait_rsp("t4b", 7);
        // Stale Done in the first poll must be ignored.
        fixed_res = 32'h1234_5678;
        mask      = 64'h5;
        flg_cfg   = 6'b010101;
        bus.req_valid = 2'b01;
        handshake("t5", g);
        push_exp(0, 32'h1234_5678, 6'b010101, 1'b0);
        bus.req_valid = 2'b00;
        wait_rsp("t5", 8);
        // Reset in the middle of POLL aborts the job silently.
        mask = 64'h0;
        bus.req_valid = 2'b01;
        handshake("t6", g);
        bus.req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_busy", 64'(bus.busy), 0);
        chk("t6_fpw_we", 64'(bus.fpw_we), 0);
        chk("t6_fpw_a", 64'(bus.fpw_a), 3);
        chk("t6_rsp_p_cleared", 64'(bus.rsp_p), 0);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.rsp_valid) cnt++;
            @(negedge clk);
        end
        chk("t6_no_rsp", 64'(cnt), 0);
        mask      = 64'h2;
        fixed_res = 32'hC0A0_0000;
        flg_cfg   = 6'b0;
        bus.req_valid = 2'b10;
        handshake("t6b", g);
        chk("t6b_gid", 64'(g), 1);
        push_exp(1, 32'hC0A0_0000, 6'b0, 1'b0);
        bus.req_valid = 2'b00;
        wait_rsp("t6b", 7);
        chk("sb_empty", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
